// File: rtl/contador_pkg.sv
// Shared definitions for the 4-bit contador counter and the checkers that monitor it.
package contador_pkg;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned CHK_CNT_W = 16;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UP3  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
  localparam logic [CHK_CNT_W-1:0] CHK_CNT_MAX = '1;

  typedef enum logic {
    StUnsync,
    StTrack
  } chk_state_t;

endpackage

// File: rtl/contador_model.sv
// Combinational next-state function of the contador counter; reusable by any checker.
module contador_model
  import contador_pkg::*;
(
  input  logic [CNT_W-1:0] q,
  input  logic             rco,
  input  logic             load,
  input  logic             dut_reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] nxt_q,
  output logic             nxt_rco,
  output logic             nxt_load
);

  always_comb begin
    nxt_q    = q;
    nxt_rco  = rco;
    nxt_load = load;
    if (dut_reset) begin
      nxt_q    = '0;
      nxt_rco  = 1'b0;
      nxt_load = 1'b0;
    end else begin
      unique case (mode)
        MODE_UP: begin
          // Disabled up-count holds all three outputs, rco included.
          if (enable) begin
            nxt_q    = q + CNT_W'(1);
            nxt_load = 1'b0;
            nxt_rco  = &nxt_q;
          end
        end
        MODE_DOWN: begin
          nxt_q    = q - CNT_W'(1);
          nxt_load = 1'b0;
          nxt_rco  = (nxt_q == '0);
        end
        MODE_UP3: begin
          nxt_q    = q + CNT_W'(3);
          nxt_load = 1'b0;
          nxt_rco  = &nxt_q;
        end
        MODE_LOAD: begin
          nxt_q    = d;
          nxt_load = 1'b1;
          nxt_rco  = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/contador_checker.sv
// Tracks the contador counter with a reference model and flags output mismatches.
module contador_checker
  import contador_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dut_reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     d,
  input  logic [CNT_W-1:0]     obs_q,
  input  logic                 obs_rco,
  input  logic                 obs_load,
  output logic                 synced,
  output logic                 err,
  output logic [2:0]           err_mask,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [CHK_CNT_W-1:0] chk_cnt,
  output logic                 fail
);

  chk_state_t       state;
  logic [CNT_W-1:0] exp_q;
  logic             exp_rco;
  logic             exp_load;

  logic [2:0]       diff;
  logic             mismatch;
  logic [CNT_W-1:0] base_q;
  logic             base_rco;
  logic             base_load;
  logic [CNT_W-1:0] nxt_q;
  logic             nxt_rco;
  logic             nxt_load;

  assign diff     = {obs_load != exp_load, obs_rco != exp_rco, obs_q != exp_q};
  assign mismatch = (state == StTrack) && (|diff);

  // Resync to what the counter actually did so a single fault is reported once.
  assign base_q    = mismatch ? obs_q    : exp_q;
  assign base_rco  = mismatch ? obs_rco  : exp_rco;
  assign base_load = mismatch ? obs_load : exp_load;

  contador_model u_model (
    .q        (base_q),
    .rco      (base_rco),
    .load     (base_load),
    .dut_reset(dut_reset),
    .enable   (enable),
    .mode     (mode),
    .d        (d),
    .nxt_q    (nxt_q),
    .nxt_rco  (nxt_rco),
    .nxt_load (nxt_load)
  );

  assign synced = (state == StTrack);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StUnsync;
      exp_q    <= '0;
      exp_rco  <= 1'b0;
      exp_load <= 1'b0;
      err      <= 1'b0;
      err_mask <= '0;
      err_cnt  <= '0;
      chk_cnt  <= '0;
      fail     <= 1'b0;
    end else begin
      unique case (state)
        StUnsync: begin
          err      <= 1'b0;
          err_mask <= '0;
          if (dut_reset || (mode == MODE_LOAD)) begin
            state    <= StTrack;
            exp_q    <= nxt_q;
            exp_rco  <= nxt_rco;
            exp_load <= nxt_load;
          end
        end
        StTrack: begin
          exp_q    <= nxt_q;
          exp_rco  <= nxt_rco;
          exp_load <= nxt_load;
          err      <= mismatch;
          err_mask <= diff;
          if (chk_cnt != CHK_CNT_MAX) chk_cnt <= chk_cnt + CHK_CNT_W'(1);
          if (mismatch) begin
            fail <= 1'b1;
            if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + ERR_CNT_W'(1);
          end
        end
        default: state <= StUnsync;
      endcase
    end
  end

endmodule

// File: doc/contador_checker.md
CONTADOR_CHECKER -- requirements
Module: contador_checker

Interface
REQ-001 clk  in  1  clock; all logic on posedge clk.
REQ-002 reset  in  1  checker reset, synchronous, active-high.
REQ-003 dut_reset  in  1  reset applied to the monitored 4-bit counter.
REQ-004 enable  in  1  counter enable, as driven to the counter.
REQ-005 mode  in  2  counter mode: 00 up+1, 01 down-1, 10 up+3, 11 load D.
REQ-006 d  in  4  counter parallel-load data.
REQ-007 obs_q / obs_rco / obs_load  in  4/1/1  observed counter outputs.
REQ-008 synced  out  1  model aligned with the counter; compares active.
REQ-009 err  out  1  one-cycle pulse per mismatching compare.
REQ-010 err_mask  out  3  {load,rco,q} fields that mismatched; valid with err.
REQ-011 err_cnt  out  8  mismatch count, saturating at 255.
REQ-012 chk_cnt  out  16  compares performed, saturating at 65535.
REQ-013 fail  out  1  sticky; set by first err, cleared only by reset.

Function
REQ-014 The checker SHALL hold a reference model (exp_q, exp_rco, exp_load) updated on the same posedge the counter samples its inputs.
REQ-015 Model next-state SHALL be:
  - dut_reset=1 (any mode): q=0, rco=0, load=0.
  - mode 00, enable=0: q, rco and load all hold.
  - mode 00, enable=1: q=q+1 mod 16, load=0, rco=(new q==4'hF).
  - mode 01, enable ignored: q=q-1 mod 16, load=0, rco=(new q==0).
  - mode 10, enable ignored: q=q+3 mod 16, load=0, rco=(new q==4'hF).
  - mode 11, enable ignored: q=d, load=1, rco=0.
REQ-016 States: UNSYNC and TRACK.
  - UNSYNC: no compares; err=0.
  - UNSYNC -> TRACK on a posedge where dut_reset=1 or mode=11; the model SHALL load per REQ-015 on that edge.
  - TRACK: every posedge SHALL compare obs_* against exp_*. One-cycle latency: the outputs produced by stimulus at edge k are checked at edge k+1.
REQ-017 Compare results (err, err_mask, counters, fail) SHALL be registered, visible the cycle after the compare edge.
REQ-018 On mismatch the model SHALL use the observed values as the base for that edge's next-state, so one fault yields exactly one err pulse.
REQ-019 chk_cnt SHALL increment on every TRACK compare; err_cnt SHALL increment on every mismatch. Both saturate and never wrap.
REQ-020 synced SHALL equal (state==TRACK).
REQ-021 When dut_reset and mode=11 are asserted on the same edge, dut_reset SHALL take priority.

Reset
REQ-022 reset=1 SHALL force:
  - state UNSYNC; synced=0, err=0, err_mask=0, err_cnt=0, chk_cnt=0, fail=0;
  - exp_q=0, exp_rco=0, exp_load=0.
REQ-023 reset SHALL take priority over all other inputs, including mid-TRACK.

Structure
REQ-024 Package contador_pkg SHALL hold:
  - mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_UP3=2'b10, MODE_LOAD=2'b11;
  - counter width 4; the UNSYNC/TRACK state type;
  - saturation limits for err_cnt and chk_cnt.
REQ-025 The REQ-015 next-state function SHALL be a combinational sub-module, contador_model, reusable by other checkers.

Verification
REQ-026 Up count: dut_reset 1 cycle, then mode 00, enable=1 for 20 cycles -> synced=1, err never set, rco seen exactly when q=F, chk_cnt=21.
REQ-027 Load then step by 3: load d=E, then mode 10 -> q=1, rco=0; load d=C, then mode 10 -> q=F, rco=1; err=0 throughout.
REQ-028 Down count: from q=0 -> F, rco=0; from q=1 -> 0, rco=1. Then enable=0 in mode 00 -> q, rco and load hold, err=0. dut_reset mid-count -> q=0, no err.
REQ-029 Single fault: corrupt obs_q bit0 for one cycle -> exactly one err pulse, err_mask=3'b001, err_cnt=1, fail=1 and stays set, no further err.
REQ-030 Before sync and saturation:
  - mismatches before the first dut_reset or load -> err=0, chk_cnt=0;
  - 300 forced mismatches -> err_cnt=255, no wrap;
  - reset -> all counters 0, synced=0.
